// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   PS/2 keyboard front end for the tank game. It conditions the raw PS/2
//   lines, frames the 11-bit PS/2 words and decodes make/break scancodes,
//   including E0-extended codes. It keeps a held/released bit for each game
//   key and exposes the decoded byte stream.
//
// Ports
//   clk_i, reset_i        system clock, synchronous active-high reset
//   ps2_clk_i, ps2_data_i raw asynchronous PS/2 lines (idle high)
//   player_1_move_o[3:0]  {right D, left A, up W, down S}, 1 = held
//   player_2_move_o[3:0]  {right E0 74, left E0 6B, up E0 75, down E0 72}
//   player_1_shoot_o      Space (29) held
//   player_2_shoot_o      Enter (5A, non-extended) held
//   scancode_o            last decoded non-prefix byte
//   scancode_ext_o        E0 preceded scancode_o
//   scancode_break_o      F0 preceded scancode_o
//   scancode_valid_o      one-cycle pulse when scancode_* update
//   frame_error_o         one-cycle pulse on parity, stop-bit or timeout error
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [3:0] player_1_move_o,
    output logic [3:0] player_2_move_o,
    output logic       player_1_shoot_o,
    output logic       player_2_shoot_o,
    output logic [7:0] scancode_o,
    output logic       scancode_ext_o,
    output logic       scancode_break_o,
    output logic       scancode_valid_o,
    output logic       frame_error_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: synchronizers, clock glitch filter, fall strobe
    // ------------------------------------------------------------------
    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic          w_fall;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data_i;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            // The filtered level only moves after FILTER_LEN differing
            // samples in a row; a single agreeing sample restarts the count.
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt;

    // ------------------------------------------------------------------
    // Frame FSM, timeout and byte decode
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;
    logic          r_par;
    logic [TW-1:0] r_tcnt;
    logic          r_ext_pend;
    logic          r_brk_pend;
    logic          w_good;

    // Odd parity over data + parity bit, and a high stop bit.
    assign w_good = (^{r_shift, r_par}) & r_dat_s2;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state          <= ST_IDLE;
            r_shift          <= '0;
            r_bitcnt         <= '0;
            r_par            <= 1'b0;
            r_tcnt           <= '0;
            r_ext_pend       <= 1'b0;
            r_brk_pend       <= 1'b0;
            player_1_move_o  <= '0;
            player_2_move_o  <= '0;
            player_1_shoot_o <= 1'b0;
            player_2_shoot_o <= 1'b0;
            scancode_o       <= '0;
            scancode_ext_o   <= 1'b0;
            scancode_break_o <= 1'b0;
            scancode_valid_o <= 1'b0;
            frame_error_o    <= 1'b0;
        end else begin
            scancode_valid_o <= 1'b0;
            frame_error_o    <= 1'b0;

            // A fall in the cycle the limit is reached wins: the counter
            // clears and no error is raised.
            if (w_fall || r_state == ST_IDLE) begin
                r_tcnt <= '0;
            end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_tcnt        <= '0;
                r_state       <= ST_IDLE;
                r_ext_pend    <= 1'b0;
                r_brk_pend    <= 1'b0;
                frame_error_o <= 1'b1;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_shift  <= '0;
                            r_bitcnt <= '0;
                            r_state  <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7)
                            r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (!w_good) begin
                            frame_error_o <= 1'b1;
                            r_ext_pend    <= 1'b0;
                            r_brk_pend    <= 1'b0;
                        end else if (r_shift == 8'hF0) begin
                            r_brk_pend <= 1'b1;
                        end else if (r_shift == 8'hE0) begin
                            r_ext_pend <= 1'b1;
                        end else begin
                            scancode_o       <= r_shift;
                            scancode_ext_o   <= r_ext_pend;
                            scancode_break_o <= r_brk_pend;
                            scancode_valid_o <= 1'b1;
                            r_ext_pend       <= 1'b0;
                            r_brk_pend       <= 1'b0;
                            // Extended and plain codes are separate keys.
                            case ({r_ext_pend, r_shift})
                                9'h023: player_1_move_o[3] <= ~r_brk_pend;
                                9'h01C: player_1_move_o[2] <= ~r_brk_pend;
                                9'h01D: player_1_move_o[1] <= ~r_brk_pend;
                                9'h01B: player_1_move_o[0] <= ~r_brk_pend;
                                9'h174: player_2_move_o[3] <= ~r_brk_pend;
                                9'h16B: player_2_move_o[2] <= ~r_brk_pend;
                                9'h175: player_2_move_o[1] <= ~r_brk_pend;
                                9'h172: player_2_move_o[0] <= ~r_brk_pend;
                                9'h029: player_1_shoot_o   <= ~r_brk_pend;
                                9'h05A: player_2_shoot_o   <= ~r_brk_pend;
                                default: ;
                            endcase
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [3:0] p1_move, p2_move;
    logic       p1_shoot, p2_shoot;
    logic [7:0] sc;
    logic       sc_ext, sc_brk, sc_vld, ferr;

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(2000)) dut (
        .clk_i(clk), .reset_i(reset), .ps2_clk_i(ps2c), .ps2_data_i(ps2d),
        .player_1_move_o(p1_move), .player_2_move_o(p2_move),
        .player_1_shoot_o(p1_shoot), .player_2_shoot_o(p2_shoot),
        .scancode_o(sc), .scancode_ext_o(sc_ext), .scancode_break_o(sc_brk),
        .scancode_valid_o(sc_vld), .frame_error_o(ferr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int cyc = 0;
    int err_cyc = 0;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sc_vld) n_valid <= n_valid + 1;
        if (ferr) begin
            n_ferr  <= n_ferr + 1;
            err_cyc <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic badpar);
        return {1'b1, (~^d) ^ badpar, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d = b[i];
            wait_cyc(40);
            ps2c = 1'b0;
            fall_cyc = cyc;
            wait_cyc(40);
            ps2c = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(frame(d, 1'b0), 11);
        ps2d = 1'b1;
        wait_cyc(20);
    endtask

    typedef struct {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       s1;
        logic       s2;
    } vec_t;

    vec_t tbl[22];

    initial begin
        int v0, e0;
        logic [3:0] sp1, sp2;
        logic [7:0] ssc;

        tbl[0]  = '{1'b0, 1'b0, 8'h1D, 4'b0010, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h1D, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h75, 4'b0000, 4'b0010, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h75, 4'b0000, 4'b0010, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 8'h75, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h23, 4'b1000, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h1C, 4'b1100, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h23, 4'b1100, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h5A, 4'b1100, 4'b0000, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 8'h5A, 4'b1100, 4'b0000, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'h5A, 4'b1100, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h1B, 4'b1100, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h6B, 4'b1100, 4'b0100, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h74, 4'b1100, 4'b1100, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'h72, 4'b1100, 4'b1101, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 8'h1C, 4'b1000, 4'b1101, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 8'h23, 4'b0000, 4'b1101, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 8'h29, 4'b0000, 4'b1101, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 8'h29, 4'b0000, 4'b1101, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 8'h6B, 4'b0000, 4'b1001, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 8'h74, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 8'h72, 4'b0000, 4'b0000, 1'b0, 1'b0};

        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(2);
        chk("rst_p1", 32'(p1_move), 0);
        chk("rst_p2", 32'(p2_move), 0);
        chk("rst_sc", 32'({sc, sc_ext, sc_brk, sc_vld, ferr, p1_shoot, p2_shoot}), 0);

        // Table-driven make/break sequences
        foreach (tbl[i]) begin
            v0 = n_valid;
            if (tbl[i].ext) send_byte(8'hE0);
            if (tbl[i].brk) send_byte(8'hF0);
            send_byte(tbl[i].code);
            chk($sformatf("v%0d_valid", i), n_valid, v0 + 1);
            chk($sformatf("v%0d_code", i), 32'(sc), 32'(tbl[i].code));
            chk($sformatf("v%0d_ext", i), 32'(sc_ext), 32'(tbl[i].ext));
            chk($sformatf("v%0d_brk", i), 32'(sc_brk), 32'(tbl[i].brk));
            chk($sformatf("v%0d_p1", i), 32'(p1_move), 32'(tbl[i].p1));
            chk($sformatf("v%0d_p2", i), 32'(p2_move), 32'(tbl[i].p2));
            chk($sformatf("v%0d_s1", i), 32'(p1_shoot), 32'(tbl[i].s1));
            chk($sformatf("v%0d_s2", i), 32'(p2_shoot), 32'(tbl[i].s2));
        end
        chk("no_err_table", n_ferr, 0);

        // Parity error, then a good frame
        v0 = n_valid; e0 = n_ferr;
        send_bits(frame(8'h29, 1'b1), 11);
        ps2d = 1'b1;
        wait_cyc(20);
        chk("par_err_cnt", n_ferr, e0 + 1);
        chk("par_no_valid", n_valid, v0);
        chk("par_shoot", 32'(p1_shoot), 0);
        send_byte(8'h29);
        chk("par_good_shoot", 32'(p1_shoot), 1);
        chk("par_good_valid", n_valid, v0 + 1);

        // Timeout on a partial frame
        e0 = n_ferr;
        send_bits(frame(8'h33, 1'b0), 5);
        ps2d = 1'b1;
        for (int k = 0; k < 3000 && n_ferr == e0; k++) wait_cyc(1);
        chk("to_err_cnt", n_ferr, e0 + 1);
        chk("to_delay", 32'((err_cyc - fall_cyc >= 1995) && (err_cyc - fall_cyc <= 2030)), 1);
        wait_cyc(50);
        v0 = n_valid;
        send_byte(8'hE0);
        send_byte(8'h5A);
        chk("to_after_valid", n_valid, v0 + 1);
        chk("to_after_code", 32'(sc), 32'h5A);
        chk("to_after_ext", 32'(sc_ext), 1);
        chk("to_after_brk", 32'(sc_brk), 0);
        chk("to_after_s2", 32'(p2_shoot), 0);
        chk("to_err_once", n_ferr, e0 + 1);

        // Short glitch on PS/2 clock while idle
        v0 = n_valid; e0 = n_ferr;
        sp1 = p1_move; sp2 = p2_move; ssc = sc;
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(100);
        chk("gl_valid", n_valid, v0);
        chk("gl_err", n_ferr, e0);
        chk("gl_outs", 32'({p1_move, p2_move, sc}), 32'({sp1, sp2, ssc}));
        send_byte(8'hF0);
        send_byte(8'h29);
        chk("gl_next_code", 32'({sc, sc_brk}), 32'({8'h29, 1'b1}));
        chk("gl_next_s1", 32'(p1_shoot), 0);
        chk("gl_next_err", n_ferr, e0);

        // Reset in the middle of a frame
        send_byte(8'h1D);
        send_byte(8'h23);
        chk("rs_pre_p1", 32'(p1_move), 32'b1010);
        send_bits(frame(8'h1B, 1'b0), 5);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rs_p1", 32'(p1_move), 0);
        chk("rs_all", 32'({p2_move, p1_shoot, p2_shoot, sc, sc_ext, sc_brk, sc_vld, ferr}), 0);
        ps2d = 1'b1;
        wait_cyc(50);
        v0 = n_valid;
        send_byte(8'h1B);
        chk("rs_fresh_p1", 32'(p1_move), 32'b0001);
        chk("rs_fresh_valid", n_valid, v0 + 1);
        chk("rs_fresh_code", 32'({sc, sc_ext, sc_brk}), 32'({8'h1B, 2'b00}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
